// File: rtl/cmp_debounce.sv
// Debounced classifier for one-hot GT/LT/EQ comparator flags: a relation becomes
// stable only after STABLE_CNT consecutive identical valid samples.
module cmp_debounce #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    input  logic             clr,
    output logic [1:0]       state_out,
    output logic             state_valid,
    output logic             change_pulse,
    output logic [CNT_W-1:0] above_cnt,
    output logic [CNT_W-1:0] below_cnt,
    output logic             err
);

    // Stable-state encoding; state_out is the FSM state register itself.
    localparam logic [1:0] ST_UNKNOWN = 2'b00;
    localparam logic [1:0] ST_ABOVE   = 2'b01;
    localparam logic [1:0] ST_BELOW   = 2'b10;
    localparam logic [1:0] ST_EQUAL   = 2'b11;

    localparam logic [7:0]       STABLE  = 8'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a sample is consumed on every rising edge where in_valid=1;
    // there is no ready, so the upstream comparator is never stalled.

    logic [1:0] cand;
    logic [7:0] run;

    logic [1:0] code;
    logic       legal;
    logic [7:0] nxt_run;
    logic       take;

    always_comb begin
        code  = ST_UNKNOWN;
        legal = 1'b1;
        case ({gt, lt, eq})
            3'b100:  code = ST_ABOVE;
            3'b010:  code = ST_BELOW;
            3'b001:  code = ST_EQUAL;
            default: legal = 1'b0;
        endcase
    end

    // Run length saturates at STABLE so a held relation never re-fires.
    always_comb begin
        nxt_run = 8'd1;
        if (code == cand) begin
            nxt_run = (run >= STABLE) ? STABLE : run + 8'd1;
        end
    end

    assign take = in_valid && legal && (nxt_run == STABLE) && (code != state_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand         <= ST_UNKNOWN;
            run          <= 8'd0;
            state_out    <= ST_UNKNOWN;
            state_valid  <= 1'b0;
            change_pulse <= 1'b0;
            err          <= 1'b0;
            above_cnt    <= '0;
            below_cnt    <= '0;
        end else begin
            change_pulse <= take;
            err          <= in_valid && !legal;

            if (in_valid) begin
                if (legal) begin
                    cand <= code;
                    run  <= nxt_run;
                end else begin
                    cand <= ST_UNKNOWN;
                    run  <= 8'd0;
                end
            end

            if (take) begin
                state_out   <= code;
                state_valid <= 1'b1;
            end

            // clr has priority over a coincident entry increment.
            if (clr) begin
                above_cnt <= '0;
            end else if (take && code == ST_ABOVE && above_cnt != CNT_MAX) begin
                above_cnt <= above_cnt + 1'b1;
            end

            if (clr) begin
                below_cnt <= '0;
            end else if (take && code == ST_BELOW && below_cnt != CNT_MAX) begin
                below_cnt <= below_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_debounce.sv
// Bench for cmp_debounce: three configurations share one stimulus stream and are
// checked against a history-window model of the debounce rule.
module tb_cmp_debounce;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic gt, lt, eq;
    logic clr;

    logic [1:0] so_a, so_b, so_c;
    logic       sv_a, sv_b, sv_c;
    logic       cp_a, cp_b, cp_c;
    logic       er_a, er_b, er_c;
    logic [7:0] ab_a, bl_a, ab_c, bl_c;
    logic [1:0] ab_b, bl_b;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmp_debounce #(.STABLE_CNT(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .lt(lt), .eq(eq),
        .clr(clr), .state_out(so_a), .state_valid(sv_a), .change_pulse(cp_a),
        .above_cnt(ab_a), .below_cnt(bl_a), .err(er_a));

    cmp_debounce #(.STABLE_CNT(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .lt(lt), .eq(eq),
        .clr(clr), .state_out(so_b), .state_valid(sv_b), .change_pulse(cp_b),
        .above_cnt(ab_b), .below_cnt(bl_b), .err(er_b));

    cmp_debounce #(.STABLE_CNT(1), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .lt(lt), .eq(eq),
        .clr(clr), .state_out(so_c), .state_valid(sv_c), .change_pulse(cp_c),
        .above_cnt(ab_c), .below_cnt(bl_c), .err(er_c));

    // ---------------- reference model ----------------
    // A relation is stable once the last N valid samples are all the same legal
    // code; illegal samples are recorded as 0 and break any window.
    logic [1:0] hist[$];
    int         n_of[3]   = '{4, 4, 1};
    int         max_of[3] = '{255, 3, 255};
    int         m_st[3];
    int         m_ab[3];
    int         m_bl[3];
    int         m_pulse[3];
    int         m_err;

    function automatic bit last_n_equal(input int n, input logic [1:0] c);
        if (hist.size() < n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (hist[hist.size() - 1 - i] != c) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_err = 0;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_ab[k] = 0; m_bl[k] = 0; m_pulse[k] = 0;
        end
    endtask

    task automatic model_edge(input logic v, input logic [2:0] f, input logic c);
        int  code;
        bit  legal;
        legal = 1'b1;
        case (f)
            3'b100:  code = 1;
            3'b010:  code = 2;
            3'b001:  code = 3;
            default: begin code = 0; legal = 1'b0; end
        endcase
        m_err = (v && !legal) ? 1 : 0;
        if (v) begin
            hist.push_back(2'(code));
            if (hist.size() > 8) void'(hist.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            m_pulse[k] = 0;
            if (v && legal && last_n_equal(n_of[k], 2'(code)) && code != m_st[k]) begin
                m_st[k]    = code;
                m_pulse[k] = 1;
                if (code == 1 && m_ab[k] < max_of[k]) m_ab[k]++;
                if (code == 2 && m_bl[k] < max_of[k]) m_bl[k]++;
            end
            if (c) begin
                m_ab[k] = 0;
                m_bl[k] = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_one(input string p, input int k, input logic [1:0] so,
                             input logic sv, input logic cp, input int ab,
                             input int bl, input logic er);
        check({p, ".state_out"},    so, m_st[k]);
        check({p, ".state_valid"},  sv, (m_st[k] != 0) ? 1 : 0);
        check({p, ".change_pulse"}, cp, m_pulse[k]);
        check({p, ".above_cnt"},    ab, m_ab[k]);
        check({p, ".below_cnt"},    bl, m_bl[k]);
        check({p, ".err"},          er, m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [2:0] f, input logic c, input logic r);
        @(negedge clk);
        in_valid = v; {gt, lt, eq} = f; clr = c; rst_n = r;
        @(posedge clk);
        if (!r) model_reset();
        else    model_edge(v, f, c);
        #1;
        check_one("a", 0, so_a, sv_a, cp_a, int'(ab_a), int'(bl_a), er_a);
        check_one("b", 1, so_b, sv_b, cp_b, int'(ab_b), int'(bl_b), er_b);
        check_one("c", 2, so_c, sv_c, cp_c, int'(ab_c), int'(bl_c), er_c);
    endtask

    task automatic samp(input logic [2:0] f);
        step(1'b1, f, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] codes[3];
        logic [2:0] cur;
        codes[0] = 3'b100; codes[1] = 3'b010; codes[2] = 3'b001;
        rst_n = 1'b0; in_valid = 1'b0; gt = 1'b0; lt = 1'b0; eq = 1'b0; clr = 1'b0;
        model_reset();

        do_reset();
        do_reset();

        // stable ABOVE after four samples
        repeat (4) samp(3'b100);
        // interrupted BELOW run
        repeat (3) samp(3'b010);
        samp(3'b001);
        repeat (4) samp(3'b010);
        // gaps do not break a run
        samp(3'b100); idle(); samp(3'b100); idle(); samp(3'b100); samp(3'b100);
        // illegal sample resets the candidate but not the state
        samp(3'b100); samp(3'b110); repeat (3) samp(3'b100);
        samp(3'b000); samp(3'b111);

        // counter saturation on the 2-bit instance
        repeat (5) begin
            repeat (4) samp(3'b010);
            repeat (4) samp(3'b100);
        end
        idle(); idle();
        // clr coincident with a BELOW entry
        repeat (3) samp(3'b010);
        step(1'b1, 3'b010, 1'b1, 1'b1);
        idle();

        // reset mid-run
        do_reset();
        repeat (2) samp(3'b001);
        do_reset();
        repeat (2) samp(3'b001);
        repeat (2) samp(3'b001);

        // single-sample debounce sequence
        do_reset();
        samp(3'b100); samp(3'b001); samp(3'b001); samp(3'b010);

        // randomized runs with gaps, illegal flags, clears and rare resets
        cur = codes[0];
        for (int i = 0; i < 800; i++) begin
            logic       v, c, r;
            logic [2:0] f;
            if ($urandom_range(0, 3) == 0) cur = codes[$urandom_range(0, 2)];
            f = cur;
            if ($urandom_range(0, 19) == 0) f = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 199) != 0);
            step(v, f, c, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
